mips_mc_ctrl: RTL and testbench

Parametrised multicycle MIPS control unit, successor to the current two-state-agnostic control block driving the multicycle datapath. It adds memory wait-state handshaking with a bounded timeout, `bne` and `addi` support, a sticky trap state for illegal encodings, and an optional retired-instruction counter. It sits beside the datapath in the CPU top and drives every datapath enable and mux select.

---
 rtl/mips_mc_pkg.sv | 59 +++++
 rtl/mips_alu_decoder.sv | 37 +++
 rtl/mips_mc_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct fields, ALU operations and datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_TRAP
  } state_e;

  // Selects how the ALU decoder derives alu_control.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_NONE  = 2'b11
  } aluop_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps (aluop, funct) to an alu_control code and
// flags whether funct is one of the supported R-type operations.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  aluop_e      i_aluop,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu_control,
  output logic        o_funct_legal
);

  logic [2:0] w_fn_ctl;

  // funct legality is reported independently of aluop so DECODE can route on it.
  always_comb begin
    w_fn_ctl      = ALU_AND;
    o_funct_legal = 1'b1;
    case (i_funct)
      FN_ADD:  w_fn_ctl = ALU_ADD;
      FN_SUB:  w_fn_ctl = ALU_SUB;
      FN_AND:  w_fn_ctl = ALU_AND;
      FN_OR:   w_fn_ctl = ALU_OR;
      FN_SLT:  w_fn_ctl = ALU_SLT;
      default: o_funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (i_aluop)
      ALUOP_ADD:   o_alu_control = ALU_ADD;
      ALUOP_SUB:   o_alu_control = ALU_SUB;
      ALUOP_FUNCT: o_alu_control = w_fn_ctl;
      default:     o_alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait states, bounded timeout and trap.
// Define MIPS_MC_CTRL_PERF_EN to build the retired-instruction counter.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_write_cond_ne,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic             alu_src_a,
  output logic             reg_write,
  output logic             reg_dst,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  localparam bit TMO_EN = (MEM_TIMEOUT > 0);
  localparam int TMO_W  = TMO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e           r_state;
  state_e           w_next;
  aluop_e           w_aluop;
  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_hit;
  logic             w_mem_state;
  logic             w_funct_legal;

  mips_alu_decoder u_alu_dec (
    .i_aluop       (w_aluop),
    .i_funct       (funct),
    .o_alu_control (alu_control),
    .o_funct_legal (w_funct_legal)
  );

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_tmo_hit   = TMO_EN && (r_tmo == TMO_W'(MEM_TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_START;
    else        r_state <= w_next;
  end

  // Any state change clears the counter, which covers entry into each memory state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_next != r_state) begin
      r_tmo <= '0;
    end else if (TMO_EN && w_mem_state && !mem_ready && !w_tmo_hit) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  // NOTE: every output and w_next gets a default before the case so no
  // path through this block can leave a value unassigned and infer a latch.
  always_comb begin
    w_next           = r_state;
    w_aluop          = ALUOP_NONE;
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    i_or_d           = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_to_reg       = 1'b0;
    ir_write         = 1'b0;
    alu_src_a        = 1'b0;
    reg_write        = 1'b0;
    reg_dst          = 1'b0;
    pc_source        = PCSRC_ALU;
    alu_src_b        = SRCB_B;
    trap             = 1'b0;

    case (r_state)
      S_START: w_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        w_aluop   = ALUOP_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_tmo_hit) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        w_aluop   = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_R:           w_next = w_funct_legal ? S_EXEC : S_TRAP;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDIEX;
          OP_J:           w_next = S_JUMP;
          default:        w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_aluop   = ALUOP_ADD;
        w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_tmo_hit) w_next = S_TRAP;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_tmo_hit) w_next = S_TRAP;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a        = 1'b1;
        w_aluop          = ALUOP_SUB;
        pc_source        = PCSRC_ALUOUT;
        pc_write_cond    = (op == OP_BEQ);
        pc_write_cond_ne = (op == OP_BNE);
        w_next           = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_aluop   = ALUOP_ADD;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: w_next = S_TRAP;
    endcase
  end

`ifdef MIPS_MC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  // An instruction retires when its last state hands control back to FETCH.
  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instr_cnt <= '0;
    else if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
  end

  assign instr_count = r_instr_cnt;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed testbench for mips_mc_ctrl (MEM_TIMEOUT=4, CNT_W=4); every cycle's
// full control word is compared against hand-written per-state constants.
module tb_mips_mc_ctrl;

  localparam int CNT_W = 4;
`ifdef MIPS_MC_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;

  // {pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
  //  mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_src_b, alu_control, trap}
  localparam logic [18:0] V_START    = 19'b00000000000_00_00_000_0;
  localparam logic [18:0] V_FETCH1   = 19'b10001001000_00_01_010_0;
  localparam logic [18:0] V_FETCH0   = 19'b00001000000_00_01_010_0;
  localparam logic [18:0] V_DECODE   = 19'b00000000000_00_11_010_0;
  localparam logic [18:0] V_MEMADR   = 19'b00000000100_00_10_010_0;
  localparam logic [18:0] V_MEMRD    = 19'b00011000000_00_00_000_0;
  localparam logic [18:0] V_MEMWB    = 19'b00000010010_00_00_000_0;
  localparam logic [18:0] V_MEMWR    = 19'b00010100000_00_00_000_0;
  localparam logic [18:0] V_EXEC_ADD = 19'b00000000100_00_00_010_0;
  localparam logic [18:0] V_EXEC_SUB = 19'b00000000100_00_00_110_0;
  localparam logic [18:0] V_EXEC_AND = 19'b00000000100_00_00_000_0;
  localparam logic [18:0] V_EXEC_OR  = 19'b00000000100_00_00_001_0;
  localparam logic [18:0] V_EXEC_SLT = 19'b00000000100_00_00_111_0;
  localparam logic [18:0] V_ALUWB    = 19'b00000000011_00_00_000_0;
  localparam logic [18:0] V_BEQ      = 19'b01000000100_01_00_110_0;
  localparam logic [18:0] V_BNE      = 19'b00100000100_01_00_110_0;
  localparam logic [18:0] V_ADDIEX   = 19'b00000000100_00_10_010_0;
  localparam logic [18:0] V_ADDIWB   = 19'b00000000010_00_00_000_0;
  localparam logic [18:0] V_JUMP     = 19'b10000000000_10_00_000_0;
  localparam logic [18:0] V_TRAP     = 19'b00000000000_00_00_000_1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       op = '0;
  logic [5:0]       funct = '0;
  logic             mem_ready = 1'b0;
  logic             pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write;
  logic             mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, trap;
  logic [1:0]       pc_source, alu_src_b;
  logic [2:0]       alu_control;
  logic [CNT_W-1:0] instr_count;
  logic [18:0]      w_obs;

  int n_checks = 0;
  int n_fail   = 0;

  mips_mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .op               (op),
    .funct            (funct),
    .mem_ready        (mem_ready),
    .pc_write         (pc_write),
    .pc_write_cond    (pc_write_cond),
    .pc_write_cond_ne (pc_write_cond_ne),
    .i_or_d           (i_or_d),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_to_reg       (mem_to_reg),
    .ir_write         (ir_write),
    .alu_src_a        (alu_src_a),
    .reg_write        (reg_write),
    .reg_dst          (reg_dst),
    .pc_source        (pc_source),
    .alu_src_b        (alu_src_b),
    .alu_control      (alu_control),
    .trap             (trap),
    .instr_count      (instr_count)
  );

  always #5 clk = ~clk;

  assign w_obs = {pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
                  mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst,
                  pc_source, alu_src_b, alu_control, trap};

  // Reset is released between edges; the following rising edge leaves START.
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b1;
  endtask

  // Advance one cycle, apply this cycle's inputs, let combinational outputs settle.
  task automatic step(input logic rdy, input logic [5:0] o, input logic [5:0] f);
    @(posedge clk);
    #2;
    mem_ready = rdy;
    op        = o;
    funct     = f;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== V_START) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", w_obs, V_START);
    end
    n_checks++;
    if (instr_count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", instr_count);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (w_obs !== V_START) begin
      n_fail++; $display("FAIL reset_held: got %b expected %b", w_obs, V_START);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== V_START) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", w_obs, V_START);
    end
    step(1'b1, T_J, 6'd0);
    n_checks++;
    if (w_obs !== V_FETCH1) begin
      n_fail++; $display("FAIL start_to_fetch: got %b expected %b", w_obs, V_FETCH1);
    end
  endtask

  task automatic test_lw;
    logic [18:0] exp [6] = '{V_FETCH1, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, T_LW, 6'd0);
      n_checks++;
      if (w_obs !== exp[i]) begin
        n_fail++; $display("FAIL lw cycle %0d: got %b expected %b", i, w_obs, exp[i]);
      end
    end
  endtask

  task automatic test_sw_wait;
    logic [18:0] exp [8] = '{V_FETCH1, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR, V_MEMWR, V_MEMWR, V_FETCH1};
    logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(rdy[i], T_SW, 6'd0);
      n_checks++;
      if (w_obs !== exp[i]) begin
        n_fail++; $display("FAIL sw_wait cycle %0d: got %b expected %b", i, w_obs, exp[i]);
      end
    end
    exp_cnt = CNT_W'(PERF);
    n_checks++;
    if (instr_count !== exp_cnt) begin
      n_fail++; $display("FAIL sw_count: got %0d expected %0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_rtype;
    logic [5:0]  fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [18:0] ex [5] = '{V_EXEC_ADD, V_EXEC_SUB, V_EXEC_AND, V_EXEC_OR, V_EXEC_SLT};
    logic [18:0] exp [4];
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp = '{V_FETCH1, V_DECODE, ex[k], V_ALUWB};
      for (int i = 0; i < 4; i++) begin
        step(1'b1, T_R, fn[k]);
        n_checks++;
        if (w_obs !== exp[i]) begin
          n_fail++; $display("FAIL rtype funct %b cycle %0d: got %b expected %b", fn[k], i, w_obs, exp[i]);
        end
      end
    end
    step(1'b1, T_R, 6'b100000);
    n_checks++;
    if (w_obs !== V_FETCH1) begin
      n_fail++; $display("FAIL rtype_return: got %b expected %b", w_obs, V_FETCH1);
    end
  endtask

  task automatic test_branch_jump;
    logic [5:0]  ops [10] = '{T_BEQ, T_BEQ, T_BEQ, T_BNE, T_BNE, T_BNE, T_J, T_J, T_J, T_ADDI};
    logic [18:0] exp [10] = '{V_FETCH1, V_DECODE, V_BEQ, V_FETCH1, V_DECODE, V_BNE,
                              V_FETCH1, V_DECODE, V_JUMP, V_FETCH1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ops[i], 6'd0);
      n_checks++;
      if (w_obs !== exp[i]) begin
        n_fail++; $display("FAIL branch_jump cycle %0d: got %b expected %b", i, w_obs, exp[i]);
      end
    end
  endtask

  task automatic test_illegal;
    do_reset();
    step(1'b1, T_R, 6'b100111);
    n_checks++;
    if (w_obs !== V_FETCH1) begin
      n_fail++; $display("FAIL illegal_fetch: got %b expected %b", w_obs, V_FETCH1);
    end
    step(1'b1, T_R, 6'b100111);
    n_checks++;
    if (w_obs !== V_DECODE) begin
      n_fail++; $display("FAIL illegal_decode: got %b expected %b", w_obs, V_DECODE);
    end
    for (int i = 0; i < 20; i++) begin
      step(i[0], T_R, 6'b100111);
      n_checks++;
      if (w_obs !== V_TRAP) begin
        n_fail++; $display("FAIL illegal_trap cycle %0d: got %b expected %b", i, w_obs, V_TRAP);
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== V_START) begin
      n_fail++; $display("FAIL trap_reset: got %b expected %b", w_obs, V_START);
    end
    do_reset();
    step(1'b1, 6'b111111, 6'd0);
    step(1'b1, 6'b111111, 6'd0);
    step(1'b1, 6'b111111, 6'd0);
    n_checks++;
    if (w_obs !== V_TRAP) begin
      n_fail++; $display("FAIL illegal_opcode: got %b expected %b", w_obs, V_TRAP);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, T_R, 6'b100000);
      n_checks++;
      if (w_obs !== V_FETCH0) begin
        n_fail++; $display("FAIL tmo_fetch cycle %0d: got %b expected %b", i, w_obs, V_FETCH0);
      end
    end
    step(1'b0, T_R, 6'b100000);
    n_checks++;
    if (w_obs !== V_TRAP) begin
      n_fail++; $display("FAIL tmo_fetch_trap: got %b expected %b", w_obs, V_TRAP);
    end
    // Ready on the last allowed cycle wins over the timeout.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, T_R, 6'b100000);
    step(1'b1, T_R, 6'b100000);
    n_checks++;
    if (w_obs !== V_FETCH1) begin
      n_fail++; $display("FAIL tmo_race_fetch: got %b expected %b", w_obs, V_FETCH1);
    end
    step(1'b1, T_R, 6'b100000);
    n_checks++;
    if (w_obs !== V_DECODE) begin
      n_fail++; $display("FAIL tmo_race_decode: got %b expected %b", w_obs, V_DECODE);
    end
    // Timeout in MEMRD.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, T_LW, 6'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, T_LW, 6'd0);
      n_checks++;
      if (w_obs !== V_MEMRD) begin
        n_fail++; $display("FAIL tmo_memrd cycle %0d: got %b expected %b", i, w_obs, V_MEMRD);
      end
    end
    step(1'b1, T_LW, 6'd0);
    n_checks++;
    if (w_obs !== V_TRAP) begin
      n_fail++; $display("FAIL tmo_memrd_trap: got %b expected %b", w_obs, V_TRAP);
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, T_SW, 6'd0);
    step(1'b0, T_SW, 6'd0);
    n_checks++;
    if (w_obs !== V_MEMWR) begin
      n_fail++; $display("FAIL mid_reset_memwr: got %b expected %b", w_obs, V_MEMWR);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== V_START) begin
      n_fail++; $display("FAIL mid_reset_abort: got %b expected %b", w_obs, V_START);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b1, T_SW, 6'd0);
    n_checks++;
    if (w_obs !== V_FETCH1) begin
      n_fail++; $display("FAIL mid_reset_restart: got %b expected %b", w_obs, V_FETCH1);
    end
  endtask

  task automatic test_back_to_back_addi;
    logic [18:0] exp [4] = '{V_FETCH1, V_DECODE, V_ADDIEX, V_ADDIWB};
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int n = 0; n < 17; n++) begin
      for (int s = 0; s < 4; s++) begin
        step(1'b1, T_ADDI, 6'd0);
        n_checks++;
        if (w_obs !== exp[s]) begin
          n_fail++; $display("FAIL addi %0d cycle %0d: got %b expected %b", n, s, w_obs, exp[s]);
        end
        if (n == 1 && s == 0) begin
          exp_cnt = CNT_W'(PERF);
          n_checks++;
          if (instr_count !== exp_cnt) begin
            n_fail++; $display("FAIL addi_count_1: got %0d expected %0d", instr_count, exp_cnt);
          end
        end
      end
    end
    step(1'b1, T_ADDI, 6'd0);
    exp_cnt = CNT_W'((17 * PERF) % 16);
    n_checks++;
    if (instr_count !== exp_cnt) begin
      n_fail++; $display("FAIL addi_count_wrap: got %0d expected %0d", instr_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_mid_reset();
    test_back_to_back_addi();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
